// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory / I/O bus arbiter.
package dmem_bus_pkg;

    // Transaction FSM: latch in IDLE, drive memory/I/O in ACCESS, ack in RESP.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Target of a latched transaction, resolved once when it is accepted.
    typedef enum logic [2:0] {
        RG_MEM,
        RG_HEX,
        RG_LEDR,
        RG_LEDG,
        RG_KEY,
        RG_SW,
        RG_NONE
    } region_e;

    // Default memory-mapped I/O addresses.
    localparam logic [31:0] DEF_ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] DEF_ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] DEF_ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] DEF_ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] DEF_ADDR_SW   = 32'hF000_0014;

    // Read value returned for addresses that hit nothing.
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // Power-on pattern of the HEX display register.
    localparam logic [15:0] HEX_RESET = 16'hDEAD;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Two requester ports plus the data-memory side of the arbiter.
interface dmem_bus_arbiter_if #(
    parameter int DBITS          = 32,
    parameter int DMEM_ADDR_BITS = 13
);
    // Port 0 (CPU)
    logic                      req0;
    logic                      we0;
    logic [DBITS-1:0]          addr0;
    logic [DBITS-1:0]          wdata0;
    logic                      ack0;
    logic [DBITS-1:0]          rdata0;
    // Port 1 (debug/DMA)
    logic                      req1;
    logic                      we1;
    logic [DBITS-1:0]          addr1;
    logic [DBITS-1:0]          wdata1;
    logic                      ack1;
    logic [DBITS-1:0]          rdata1;
    // Data memory
    logic                      mem_en;
    logic                      mem_we;
    logic [DMEM_ADDR_BITS-3:0] mem_addr;
    logic [DBITS-1:0]          mem_wdata;
    logic [DBITS-1:0]          mem_rdata;

    // Arbiter view: serves requesters, drives the memory.
    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory-model view.
    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_bus_arbiter_rr_arb2.sv
// Two-port round-robin grant. A lone request always wins; on a tie the port
// not granted last wins. The pointer moves only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0: port 0 favored on a tie, 1: port 1 favored
    logic prio_q, prio_d;

    // Grant selection and pointer update
    always_comb begin
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
        prio_d = prio_q;
        if (accept && (req != 2'b00)) begin
            // Whoever just won yields the next tie to the other port
            prio_d = grant[0];
        end
    end

    // Pointer register, port 0 favored out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates two requesters onto data memory and a small set of I/O registers.
// Each transaction takes IDLE -> ACCESS -> RESP, acking in RESP.
module dmem_bus_arbiter
    import dmem_bus_pkg::*;
#(
    parameter int               DBITS          = 32,
    parameter int               DMEM_ADDR_BITS = 13,
    parameter logic [DBITS-1:0] ADDR_HEX       = DEF_ADDR_HEX,
    parameter logic [DBITS-1:0] ADDR_LEDR      = DEF_ADDR_LEDR,
    parameter logic [DBITS-1:0] ADDR_LEDG      = DEF_ADDR_LEDG,
    parameter logic [DBITS-1:0] ADDR_KEY       = DEF_ADDR_KEY,
    parameter logic [DBITS-1:0] ADDR_SW        = DEF_ADDR_SW
) (
    input  logic                clk,
    input  logic                reset,
    dmem_bus_arbiter_if.slave   bus,
    input  logic [3:0]          key,
    input  logic [9:0]          sw,
    output logic [15:0]         hex_out,
    output logic [9:0]          ledr_out,
    output logic [7:0]          ledg_out
);

    logic [1:0] req, grant;
    logic       accept;

    state_e                    state_q, state_d;
    logic                      port_q, port_d;
    logic                      we_q, we_d;
    logic [DMEM_ADDR_BITS-3:0] maddr_q, maddr_d;
    logic [DBITS-1:0]          wdata_q, wdata_d;
    region_e                   region_q, region_d;
    logic [1:0]                ack_q, ack_d;
    logic                      mem_en_q, mem_en_d;
    logic                      mem_we_q, mem_we_d;
    logic [15:0]               hex_q, hex_d;
    logic [9:0]                ledr_q, ledr_d;
    logic [7:0]                ledg_q, ledg_d;

    logic             win_port, win_we;
    logic [DBITS-1:0] win_addr, win_wdata;
    region_e          win_region;
    logic [DBITS-1:0] rd_val;

    // Memory window is everything below 2**DMEM_ADDR_BITS; I/O needs an exact hit.
    function automatic region_e decode(input logic [DBITS-1:0] a);
        if (a[DBITS-1:DMEM_ADDR_BITS] == '0) return RG_MEM;
        if (a == ADDR_HEX)  return RG_HEX;
        if (a == ADDR_LEDR) return RG_LEDR;
        if (a == ADDR_LEDG) return RG_LEDG;
        if (a == ADDR_KEY)  return RG_KEY;
        if (a == ADDR_SW)   return RG_SW;
        return RG_NONE;
    endfunction

    assign req    = {bus.req1, bus.req0};
    assign accept = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // Select the winning port's request fields
    always_comb begin
        win_port   = grant[1];
        win_we     = win_port ? bus.we1    : bus.we0;
        win_addr   = win_port ? bus.addr1  : bus.addr0;
        win_wdata  = win_port ? bus.wdata1 : bus.wdata0;
        win_region = decode(win_addr);
    end

    // Next-state logic for the FSM, transaction latch and I/O registers
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        region_d = region_q;
        ack_d    = 2'b00;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        hex_d    = hex_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d  = ST_ACCESS;
                    port_d   = win_port;
                    we_d     = win_we;
                    maddr_d  = win_addr[DMEM_ADDR_BITS-1:2];
                    wdata_d  = win_wdata;
                    region_d = win_region;
                    // Memory strobes are registered so they are clean in ACCESS
                    mem_en_d = (win_region == RG_MEM);
                    mem_we_d = win_we;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                ack_d   = port_q ? 2'b10 : 2'b01;
                // I/O writes commit on the ACCESS -> RESP edge
                if (we_q) begin
                    case (region_q)
                        RG_HEX:  hex_d  = wdata_q[15:0];
                        RG_LEDR: ledr_d = wdata_q[9:0];
                        RG_LEDG: ledg_d = wdata_q[7:0];
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All arbiter state; reset aborts any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            wdata_q  <= '0;
            region_q <= RG_NONE;
            ack_q    <= 2'b00;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            hex_q    <= HEX_RESET;
            ledr_q   <= '0;
            ledg_q   <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
            region_q <= region_d;
            ack_q    <= ack_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
        end
    end

    // Read-data source; mem_rdata only becomes valid in RESP, so this stays combinational
    always_comb begin
        rd_val = '0;
        case (region_q)
            RG_MEM:  rd_val = bus.mem_rdata;
            RG_KEY:  rd_val = {{(DBITS-4){1'b0}}, ~key};
            RG_SW:   rd_val = {{(DBITS-10){1'b0}}, sw};
            RG_HEX:  rd_val = {{(DBITS-16){1'b0}}, hex_q};
            RG_LEDR: rd_val = {{(DBITS-10){1'b0}}, ledr_q};
            RG_LEDG: rd_val = {{(DBITS-8){1'b0}}, ledg_q};
            RG_NONE: rd_val = DBITS'(UNMAPPED_RDATA);
            default: rd_val = '0;
        endcase
    end

    // Read data only on the acked port and only for reads
    always_comb begin
        bus.rdata0 = (ack_q[0] && !we_q) ? rd_val : '0;
        bus.rdata1 = (ack_q[1] && !we_q) ? rd_val : '0;
    end

    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign hex_out       = hex_q;
    assign ledr_out      = ledr_q;
    assign ledg_out      = ledg_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a one-cycle-latency memory model.
module tb_dmem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    int checks = 0;
    int errors = 0;

    dmem_bus_arbiter_if bus ();

    dmem_bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .key      (key),
        .sw       (sw),
        .hex_out  (hex_out),
        .ledr_out (ledr_out),
        .ledg_out (ledg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, data valid the cycle after mem_en
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE: request, ACCESS, RESP, back to IDLE.
    task automatic do_txn(input string tag, input bit port, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit exp_men, input logic [31:0] exp_maddr,
                          input logic [31:0] exp_rdata);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        tick();  // ACCESS
        chk({tag, "/acc_men"}, {31'b0, bus.mem_en}, {31'b0, exp_men});
        chk({tag, "/acc_mwe"}, {31'b0, bus.mem_we}, {31'b0, we});
        if (exp_men) chk({tag, "/acc_maddr"}, {21'b0, bus.mem_addr}, exp_maddr);
        chk({tag, "/acc_acks"}, {30'b0, bus.ack1, bus.ack0}, 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();  // RESP
        chk({tag, "/resp_acks"}, {30'b0, bus.ack1, bus.ack0}, port ? 32'd2 : 32'd1);
        chk({tag, "/resp_rdata"}, port ? bus.rdata1 : bus.rdata0, exp_rdata);
        chk({tag, "/resp_other_rdata"}, port ? bus.rdata0 : bus.rdata1, 32'd0);
        chk({tag, "/resp_men"}, {31'b0, bus.mem_en}, 32'd0);
        tick();  // IDLE
        chk({tag, "/idle_acks"}, {30'b0, bus.ack1, bus.ack0}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        key = 4'hF;
        sw = 10'h0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_hex", {16'b0, hex_out}, 32'h0000_DEAD);
        chk("rst_ledr", {22'b0, ledr_out}, 32'd0);
        chk("rst_ledg", {24'b0, ledg_out}, 32'd0);
        chk("rst_acks", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst_men", {30'b0, bus.mem_we, bus.mem_en}, 32'd0);
        chk("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);
        reset = 1'b0;

        // Both ports request continuously: 0,1,0,1 with acks 3 cycles apart
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h100; bus.wdata0 = 32'hAAAA_0000;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h104; bus.wdata1 = 32'hBBBB_1111;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("rr_ack0_c%0d", i), {31'b0, bus.ack0}, {31'b0, (i == 2 || i == 8)});
            chk($sformatf("rr_ack1_c%0d", i), {31'b0, bus.ack1}, {31'b0, (i == 5 || i == 11)});
            if (i == 11) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        do_txn("rr_rb0", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h40, 32'hAAAA_0000);
        do_txn("rr_rb1", 1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 32'h41, 32'hBBBB_1111);

        // Memory write then read-back on port 0
        do_txn("w40", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 32'h10, 32'h0);
        do_txn("r40", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h10, 32'h1234_5678);

        // Top word of the memory window, and first address past it
        do_txn("w1ffc", 1'b1, 1'b1, 32'h1FFC, 32'hCAFE_F00D, 1'b1, 32'h7FF, 32'h0);
        do_txn("r1ffc", 1'b0, 1'b0, 32'h1FFC, 32'h0, 1'b1, 32'h7FF, 32'hCAFE_F00D);
        do_txn("r2000", 1'b0, 1'b0, 32'h2000, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // I/O registers and inputs
        do_txn("whex", 1'b1, 1'b1, 32'hF000_0000, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0);
        chk("hex_after_write", {16'b0, hex_out}, 32'h0000_BEEF);
        key = 4'b1110;
        do_txn("rkey", 1'b1, 1'b0, 32'hF000_0010, 32'h0, 1'b0, 32'h0, 32'h1);
        sw = 10'h2A5;
        do_txn("rsw", 1'b0, 1'b0, 32'hF000_0014, 32'h0, 1'b0, 32'h0, 32'h2A5);
        do_txn("wledg", 1'b0, 1'b1, 32'hF000_0008, 32'h1FF, 1'b0, 32'h0, 32'h0);
        chk("ledg_after_write", {24'b0, ledg_out}, 32'hFF);
        do_txn("rledg", 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b0, 32'h0, 32'hFF);
        do_txn("wledr", 1'b0, 1'b1, 32'hF000_0004, 32'h155, 1'b0, 32'h0, 32'h0);
        chk("ledr_after_write", {22'b0, ledr_out}, 32'h155);
        do_txn("rledr", 1'b0, 1'b0, 32'hF000_0004, 32'h0, 1'b0, 32'h0, 32'h155);
        do_txn("wkey", 1'b1, 1'b1, 32'hF000_0010, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
        chk("wkey_hex", {16'b0, hex_out}, 32'h0000_BEEF);
        chk("wkey_ledr", {22'b0, ledr_out}, 32'h155);
        chk("wkey_ledg", {24'b0, ledg_out}, 32'hFF);

        // Unmapped region
        do_txn("rumap", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        do_txn("wumap", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        chk("wumap_hex", {16'b0, hex_out}, 32'h0000_BEEF);
        chk("wumap_ledr", {22'b0, ledr_out}, 32'h155);
        chk("wumap_ledg", {24'b0, ledg_out}, 32'hFF);

        // Reset during ACCESS of a LEDR write aborts it
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'hF000_0004; bus.wdata0 = 32'h3FF;
        tick();  // ACCESS
        chk("abort_acc_men", {31'b0, bus.mem_en}, 32'd0);
        reset = 1'b1;
        bus.req0 = 1'b0;
        #1;
        chk("abort_ledr_now", {22'b0, ledr_out}, 32'd0);
        chk("abort_hex_now", {16'b0, hex_out}, 32'h0000_DEAD);
        chk("abort_acks_now", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        tick();
        chk("abort_acks_held", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_acks_after", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        chk("abort_ledr_after", {22'b0, ledr_out}, 32'd0);
        tick();
        chk("abort_acks_later", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        chk("abort_ledr_later", {22'b0, ledr_out}, 32'd0);
        do_txn("post_abort_rledr", 1'b1, 1'b0, 32'hF000_0004, 32'h0, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
